// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rob_pkg
//  Purpose  : Shared kind encodings, null tag and tag wrap helper for the ROB.
//  Revision : 1.0  initial release
// ============================================================================
package rob_pkg;

    typedef enum logic [1:0] {
        KIND_NORMAL = 2'd0,
        KIND_STORE  = 2'd1,
        KIND_BRANCH = 2'd2,
        KIND_JALR   = 2'd3
    } kind_t;

    localparam int NULL_TAG = 0;

    // Tags live in 1..depth; tag 0 is reserved as the null tag.
    function automatic int tag_next(input int tag, input int depth);
        return (tag >= depth) ? 1 : tag + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rob_flush_multiwb_if.sv
`default_nettype none
// ============================================================================
//  Module   : rob_flush_multiwb_if
//  Purpose  : Alloc / writeback / query / commit bundle of the reorder buffer.
//  Revision : 1.0  initial release
// ============================================================================
interface rob_flush_multiwb_if #(
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int N_WB   = 2
);
    logic                   ena;
    logic                   in_alloc_ena;
    logic [1:0]             in_alloc_kind;
    logic [REG_W-1:0]       in_alloc_dest;
    logic [DATA_W-1:0]      in_alloc_pc;
    logic                   in_alloc_pred_taken;
    logic [TAG_W-1:0]       out_alloc_tag;
    logic                   out_alloc_ok;
    logic [N_WB*TAG_W-1:0]  in_wb_tag;
    logic [N_WB*DATA_W-1:0] in_wb_value;
    logic [N_WB-1:0]        in_wb_taken;
    logic [N_WB*DATA_W-1:0] in_wb_target;
    logic [TAG_W-1:0]       in_query_tag1;
    logic [TAG_W-1:0]       in_query_tag2;
    logic                   out_query_ready1;
    logic                   out_query_ready2;
    logic [DATA_W-1:0]      out_query_value1;
    logic [DATA_W-1:0]      out_query_value2;
    logic [REG_W-1:0]       out_reg_reg;
    logic [TAG_W-1:0]       out_reg_rob;
    logic [DATA_W-1:0]      out_reg_value;
    logic [TAG_W-1:0]       out_store_commit_tag;
    logic                   out_fwd_ena;
    logic [DATA_W-1:0]      out_fwd_pc;
    logic                   out_fwd_taken;
    logic                   out_misbranch;
    logic [DATA_W-1:0]      out_correct_addr;
    logic [TAG_W:0]         out_count;

    modport master (
        output ena, in_alloc_ena, in_alloc_kind, in_alloc_dest, in_alloc_pc,
               in_alloc_pred_taken, in_wb_tag, in_wb_value, in_wb_taken,
               in_wb_target, in_query_tag1, in_query_tag2,
        input  out_alloc_tag, out_alloc_ok, out_query_ready1, out_query_ready2,
               out_query_value1, out_query_value2, out_reg_reg, out_reg_rob,
               out_reg_value, out_store_commit_tag, out_fwd_ena, out_fwd_pc,
               out_fwd_taken, out_misbranch, out_correct_addr, out_count
    );

    modport slave (
        input  ena, in_alloc_ena, in_alloc_kind, in_alloc_dest, in_alloc_pc,
               in_alloc_pred_taken, in_wb_tag, in_wb_value, in_wb_taken,
               in_wb_target, in_query_tag1, in_query_tag2,
        output out_alloc_tag, out_alloc_ok, out_query_ready1, out_query_ready2,
               out_query_value1, out_query_value2, out_reg_reg, out_reg_rob,
               out_reg_value, out_store_commit_tag, out_fwd_ena, out_fwd_pc,
               out_fwd_taken, out_misbranch, out_correct_addr, out_count
    );
endinterface
`default_nettype wire

// File: rtl/rob_wb_select.sv
`default_nettype none
// ============================================================================
//  Module   : rob_wb_select
//  Purpose  : N-way writeback tag match; highest matching channel wins.
//  Revision : 1.0  initial release
// ============================================================================
module rob_wb_select
    import rob_pkg::*;
#(
    parameter int N_WB  = 2,
    parameter int TAG_W = 5,
    parameter int PAY_W = 32
) (
    input  logic [N_WB*TAG_W-1:0] i_wb_tag,
    input  logic [N_WB*PAY_W-1:0] i_wb_pay,
    input  logic [TAG_W-1:0]      i_query_tag,
    output logic                  o_hit,
    output logic [PAY_W-1:0]      o_pay
);
    always_comb begin
        o_hit = 1'b0;
        o_pay = '0;
        // Ascending scan so a later (higher) channel overrides an earlier one.
        for (int ch = 0; ch < N_WB; ch++) begin
            if (i_query_tag != TAG_W'(NULL_TAG) &&
                i_wb_tag[ch*TAG_W +: TAG_W] == i_query_tag) begin
                o_hit = 1'b1;
                o_pay = i_wb_pay[ch*PAY_W +: PAY_W];
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/rob_flush_multiwb.sv
`default_nettype none
// ============================================================================
//  Module   : rob_flush_multiwb
//  Purpose  : Multi-writeback reorder buffer with in-order commit and flush.
//  Revision : 1.0  initial release
// ============================================================================
module rob_flush_multiwb
    import rob_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int N_WB   = 2
) (
    input  logic               clk,
    input  logic               rst,
    rob_flush_multiwb_if.slave bus
);
    localparam int               c_ent_w = 2 * DATA_W + 1;
    localparam logic [TAG_W:0]   c_depth = DEPTH[TAG_W:0];
    localparam logic [TAG_W-1:0] c_first = TAG_W'(1);

    kind_t             r_kind   [0:DEPTH];
    logic [REG_W-1:0]  r_dest   [0:DEPTH];
    logic [DATA_W-1:0] r_pc     [0:DEPTH];
    logic [DATA_W-1:0] r_value  [0:DEPTH];
    logic [DATA_W-1:0] r_target [0:DEPTH];
    logic [DEPTH:0]    r_pred;
    logic [DEPTH:0]    r_taken;
    logic [DEPTH:0]    r_ready;
    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [TAG_W:0]    r_count;

    logic [N_WB*c_ent_w-1:0] w_wb_ent;
    logic [DEPTH:1]          w_wb_hit;
    logic [DEPTH:1]          w_live;
    logic [c_ent_w-1:0]      w_wb_pay [1:DEPTH];
    logic                    w_alloc;
    logic                    w_commit;
    logic                    w_flush;
    logic                    w_q1_hit, w_q2_hit;
    logic [DATA_W-1:0]       w_q1_val, w_q2_val;

    for (genvar ch = 0; ch < N_WB; ch++) begin : g_pay
        assign w_wb_ent[ch*c_ent_w +: c_ent_w] = {bus.in_wb_taken[ch],
                                                  bus.in_wb_target[ch*DATA_W +: DATA_W],
                                                  bus.in_wb_value[ch*DATA_W +: DATA_W]};
    end

    // Per-entry write arbitration and liveness (offset from head below count).
    for (genvar e = 1; e <= DEPTH; e++) begin : g_entry
        localparam int c_e = e;
        rob_wb_select #(.N_WB(N_WB), .TAG_W(TAG_W), .PAY_W(c_ent_w)) u_sel (
            .i_wb_tag   (bus.in_wb_tag),
            .i_wb_pay   (w_wb_ent),
            .i_query_tag(TAG_W'(c_e)),
            .o_hit      (w_wb_hit[e]),
            .o_pay      (w_wb_pay[e])
        );
        assign w_live[e] = (c_e >= int'(r_head)) ?
                           ((c_e - int'(r_head)) < int'(r_count)) :
                           ((c_e + DEPTH - int'(r_head)) < int'(r_count));
    end

    rob_wb_select #(.N_WB(N_WB), .TAG_W(TAG_W), .PAY_W(DATA_W)) u_q1 (
        .i_wb_tag(bus.in_wb_tag), .i_wb_pay(bus.in_wb_value),
        .i_query_tag(bus.in_query_tag1), .o_hit(w_q1_hit), .o_pay(w_q1_val)
    );
    rob_wb_select #(.N_WB(N_WB), .TAG_W(TAG_W), .PAY_W(DATA_W)) u_q2 (
        .i_wb_tag(bus.in_wb_tag), .i_wb_pay(bus.in_wb_value),
        .i_query_tag(bus.in_query_tag2), .o_hit(w_q2_hit), .o_pay(w_q2_val)
    );

    always_comb begin
        bus.out_query_ready1 = 1'b0;
        bus.out_query_value1 = '0;
        bus.out_query_ready2 = 1'b0;
        bus.out_query_value2 = '0;
        if (bus.in_query_tag1 != TAG_W'(NULL_TAG)) begin
            bus.out_query_ready1 = w_q1_hit | r_ready[bus.in_query_tag1];
            bus.out_query_value1 = w_q1_hit ? w_q1_val : r_value[bus.in_query_tag1];
        end
        if (bus.in_query_tag2 != TAG_W'(NULL_TAG)) begin
            bus.out_query_ready2 = w_q2_hit | r_ready[bus.in_query_tag2];
            bus.out_query_value2 = w_q2_hit ? w_q2_val : r_value[bus.in_query_tag2];
        end
    end

    assign w_alloc  = bus.ena && bus.in_alloc_ena && (r_count < c_depth);
    assign w_commit = bus.ena && (r_count != '0) && r_ready[r_head];
    assign w_flush  = w_commit && ((r_kind[r_head] == KIND_JALR) ||
                      (r_kind[r_head] == KIND_BRANCH && r_taken[r_head] != r_pred[r_head]));

    assign bus.out_alloc_ok  = (r_count < c_depth);
    assign bus.out_alloc_tag = (r_count < c_depth) ? r_tail : TAG_W'(NULL_TAG);
    assign bus.out_count     = r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head                   <= c_first;
            r_tail                   <= c_first;
            r_count                  <= '0;
            r_ready                  <= '0;
            bus.out_reg_reg          <= '0;
            bus.out_reg_rob          <= '0;
            bus.out_reg_value        <= '0;
            bus.out_store_commit_tag <= '0;
            bus.out_fwd_ena          <= 1'b0;
            bus.out_fwd_pc           <= '0;
            bus.out_fwd_taken        <= 1'b0;
            bus.out_misbranch        <= 1'b0;
            bus.out_correct_addr     <= '0;
        end else if (bus.ena) begin
            bus.out_reg_reg          <= '0;
            bus.out_reg_rob          <= '0;
            bus.out_reg_value        <= '0;
            bus.out_store_commit_tag <= '0;
            bus.out_fwd_ena          <= 1'b0;
            bus.out_fwd_pc           <= '0;
            bus.out_fwd_taken        <= 1'b0;
            bus.out_misbranch        <= 1'b0;
            bus.out_correct_addr     <= '0;
            if (w_commit) begin
                r_ready[r_head] <= 1'b0;
                case (r_kind[r_head])
                    KIND_NORMAL: begin
                        bus.out_reg_reg   <= r_dest[r_head];
                        bus.out_reg_rob   <= r_head;
                        bus.out_reg_value <= r_value[r_head];
                    end
                    KIND_STORE: bus.out_store_commit_tag <= r_head;
                    KIND_BRANCH: begin
                        bus.out_fwd_ena   <= 1'b1;
                        bus.out_fwd_pc    <= r_pc[r_head];
                        bus.out_fwd_taken <= r_taken[r_head];
                        if (w_flush) begin
                            bus.out_misbranch    <= 1'b1;
                            bus.out_correct_addr <= r_target[r_head];
                        end
                    end
                    KIND_JALR: begin
                        bus.out_reg_reg      <= r_dest[r_head];
                        bus.out_reg_rob      <= r_head;
                        bus.out_reg_value    <= r_value[r_head];
                        bus.out_fwd_ena      <= 1'b1;
                        bus.out_fwd_pc       <= r_pc[r_head];
                        bus.out_fwd_taken    <= 1'b1;
                        bus.out_misbranch    <= 1'b1;
                        bus.out_correct_addr <= r_target[r_head];
                    end
                endcase
            end
            // A flush discards this cycle's allocation and writebacks too.
            if (w_flush) begin
                r_head  <= c_first;
                r_tail  <= c_first;
                r_count <= '0;
                r_ready <= '0;
            end else begin
                for (int i = 1; i <= DEPTH; i++) begin
                    if (w_wb_hit[i] && w_live[i]) begin
                        r_ready[i] <= 1'b1;
                        {r_taken[i], r_target[i], r_value[i]} <= w_wb_pay[i];
                    end
                end
                if (w_alloc) begin
                    r_kind[r_tail]  <= kind_t'(bus.in_alloc_kind);
                    r_dest[r_tail]  <= bus.in_alloc_dest;
                    r_pc[r_tail]    <= bus.in_alloc_pc;
                    r_pred[r_tail]  <= bus.in_alloc_pred_taken;
                    r_ready[r_tail] <= 1'b0;
                    r_tail          <= TAG_W'(tag_next(int'(r_tail), DEPTH));
                end
                if (w_commit) begin
                    r_head <= TAG_W'(tag_next(int'(r_head), DEPTH));
                end
                case ({w_alloc, w_commit})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_rob_flush_multiwb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rob_flush_multiwb
//  Purpose  : Directed self-checking bench for rob_flush_multiwb.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rob_flush_multiwb;
    import rob_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    rob_flush_multiwb_if bus ();
    rob_flush_multiwb dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ena                 = 1'b1;
        bus.in_alloc_ena        = 1'b0;
        bus.in_alloc_kind       = 2'd0;
        bus.in_alloc_dest       = '0;
        bus.in_alloc_pc         = '0;
        bus.in_alloc_pred_taken = 1'b0;
        bus.in_wb_tag           = '0;
        bus.in_wb_value         = '0;
        bus.in_wb_taken         = '0;
        bus.in_wb_target        = '0;
        bus.in_query_tag1       = '0;
        bus.in_query_tag2       = '0;
    endtask

    task automatic alloc(input logic [1:0] kind, input logic [4:0] dest,
                         input logic [31:0] pc, input logic pred);
        bus.in_alloc_ena        = 1'b1;
        bus.in_alloc_kind       = kind;
        bus.in_alloc_dest       = dest;
        bus.in_alloc_pc         = pc;
        bus.in_alloc_pred_taken = pred;
    endtask

    task automatic wb(input int ch, input logic [4:0] tag, input logic [31:0] value,
                      input logic taken, input logic [31:0] target);
        bus.in_wb_tag[ch*5 +: 5]     = tag;
        bus.in_wb_value[ch*32 +: 32] = value;
        bus.in_wb_taken[ch]          = taken;
        bus.in_wb_target[ch*32 +: 32] = target;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_count", bus.out_count, 0);
        chk("rst_alloc_tag", bus.out_alloc_tag, 1);
        chk("rst_alloc_ok", bus.out_alloc_ok, 1);
        chk("rst_reg_reg", bus.out_reg_reg, 0);
        chk("rst_reg_value", bus.out_reg_value, 0);
        chk("rst_store_tag", bus.out_store_commit_tag, 0);
        chk("rst_fwd_ena", bus.out_fwd_ena, 0);
        chk("rst_misbranch", bus.out_misbranch, 0);
        chk("rst_correct_addr", bus.out_correct_addr, 0);

        // Fill to DEPTH, then one extra allocation that must be ignored
        for (int k = 0; k < 16; k++) begin
            alloc(KIND_NORMAL, 5'd1, 32'h0, 1'b0);
            step();
        end
        idle();
        chk("full_count", bus.out_count, 16);
        chk("full_alloc_ok", bus.out_alloc_ok, 0);
        chk("full_alloc_tag", bus.out_alloc_tag, 0);
        alloc(KIND_NORMAL, 5'd1, 32'h0, 1'b0);
        step();
        idle();
        chk("full_extra_count", bus.out_count, 16);

        // Bypass on channel 1, then commit one cycle after head became ready
        do_reset();
        alloc(KIND_NORMAL, 5'd5, 32'h10, 1'b0);
        step();
        idle();
        wb(1, 5'd1, 32'hDEAD, 1'b0, 32'h0);
        bus.in_query_tag1 = 5'd1;
        #1;
        chk("byp_ready1", bus.out_query_ready1, 1);
        chk("byp_value1", bus.out_query_value1, 32'hDEAD);
        chk("q_null_ready2", bus.out_query_ready2, 0);
        chk("q_null_value2", bus.out_query_value2, 0);
        step();
        idle();
        chk("wb_edge_no_commit", bus.out_reg_reg, 0);
        step();
        chk("commit_reg_reg", bus.out_reg_reg, 5);
        chk("commit_reg_value", bus.out_reg_value, 32'hDEAD);
        chk("commit_reg_rob", bus.out_reg_rob, 1);
        chk("commit_count", bus.out_count, 0);
        step();
        chk("commit_pulse", bus.out_reg_reg, 0);

        // Mispredicted branch flushes, dropping same-cycle alloc and writeback
        do_reset();
        alloc(KIND_BRANCH, 5'd0, 32'h40, 1'b0);
        step();
        for (int k = 0; k < 3; k++) begin
            alloc(KIND_NORMAL, 5'd2, 32'h44, 1'b0);
            step();
        end
        idle();
        chk("br_count", bus.out_count, 4);
        wb(0, 5'd1, 32'h0, 1'b1, 32'h100);
        step();
        idle();
        alloc(KIND_NORMAL, 5'd3, 32'h48, 1'b0);
        wb(1, 5'd2, 32'h77, 1'b0, 32'h0);
        step();
        idle();
        chk("br_misbranch", bus.out_misbranch, 1);
        chk("br_correct_addr", bus.out_correct_addr, 32'h100);
        chk("br_fwd_ena", bus.out_fwd_ena, 1);
        chk("br_fwd_taken", bus.out_fwd_taken, 1);
        chk("br_fwd_pc", bus.out_fwd_pc, 32'h40);
        chk("br_reg_reg", bus.out_reg_reg, 0);
        chk("br_flush_count", bus.out_count, 0);
        chk("br_flush_alloc_tag", bus.out_alloc_tag, 1);
        bus.in_query_tag1 = 5'd2;
        #1;
        chk("br_flush_wb_dropped", bus.out_query_ready1, 0);
        step();
        chk("br_misbranch_pulse", bus.out_misbranch, 0);

        // Tag wrap: 20 NORMALs, each retired before the next is allocated
        for (int k = 0; k < 20; k++) begin
            idle();
            alloc(KIND_NORMAL, 5'((k % 30) + 1), 32'(k), 1'b0);
            #1;
            chk("wrap_alloc_tag", bus.out_alloc_tag, (k % 16) + 1);
            step();
            idle();
            wb(k % 2, 5'((k % 16) + 1), 32'h1000 + 32'(k), 1'b0, 32'h0);
            step();
            idle();
            step();
            chk("wrap_reg_rob", bus.out_reg_rob, (k % 16) + 1);
            chk("wrap_reg_value", bus.out_reg_value, 32'h1000 + k);
            chk("wrap_reg_reg", bus.out_reg_reg, (k % 30) + 1);
            chk("wrap_count", bus.out_count, 0);
        end

        // Same tag on both channels: channel 1 wins; then a STORE commit
        do_reset();
        alloc(KIND_NORMAL, 5'd1, 32'h0, 1'b0); step();
        alloc(KIND_NORMAL, 5'd2, 32'h4, 1'b0); step();
        alloc(KIND_NORMAL, 5'd3, 32'h8, 1'b0); step();
        alloc(KIND_STORE, 5'd0, 32'hC, 1'b0);  step();
        idle();
        wb(0, 5'd1, 32'hA, 1'b0, 32'h0);
        wb(1, 5'd2, 32'hB, 1'b0, 32'h0);
        step();
        idle();
        wb(0, 5'd3, 32'h11, 1'b0, 32'h0);
        wb(1, 5'd3, 32'h22, 1'b0, 32'h0);
        bus.in_query_tag1 = 5'd3;
        #1;
        chk("tie_bypass_value", bus.out_query_value1, 32'h22);
        step();
        chk("tie_commit1_rob", bus.out_reg_rob, 1);
        chk("tie_commit1_value", bus.out_reg_value, 32'hA);
        idle();
        wb(0, 5'd4, 32'h0, 1'b0, 32'h0);
        step();
        idle();
        chk("tie_commit2_value", bus.out_reg_value, 32'hB);
        step();
        chk("tie_commit3_value", bus.out_reg_value, 32'h22);
        chk("tie_commit3_reg", bus.out_reg_reg, 3);
        step();
        chk("store_tag", bus.out_store_commit_tag, 4);
        chk("store_reg_reg", bus.out_reg_reg, 0);
        chk("store_count", bus.out_count, 0);

        // ena=0 blocks allocation and writeback
        alloc(KIND_NORMAL, 5'd9, 32'h20, 1'b0);
        step();
        idle();
        alloc(KIND_NORMAL, 5'd10, 32'h24, 1'b0);
        wb(0, 5'd5, 32'h9, 1'b0, 32'h0);
        bus.ena = 1'b0;
        step();
        chk("ena0_count", bus.out_count, 1);
        idle();
        step();
        chk("ena0_wb_ignored", bus.out_reg_rob, 0);

        // JALR always redirects and writes its link register
        alloc(KIND_JALR, 5'd7, 32'h80, 1'b0);
        wb(0, 5'd5, 32'h1, 1'b0, 32'h0);
        step();
        idle();
        wb(1, 5'd6, 32'h84, 1'b1, 32'h200);
        step();
        idle();
        chk("jalr_prev_rob", bus.out_reg_rob, 5);
        chk("jalr_prev_count", bus.out_count, 1);
        step();
        chk("jalr_reg_reg", bus.out_reg_reg, 7);
        chk("jalr_reg_value", bus.out_reg_value, 32'h84);
        chk("jalr_reg_rob", bus.out_reg_rob, 6);
        chk("jalr_fwd_ena", bus.out_fwd_ena, 1);
        chk("jalr_fwd_taken", bus.out_fwd_taken, 1);
        chk("jalr_fwd_pc", bus.out_fwd_pc, 32'h80);
        chk("jalr_misbranch", bus.out_misbranch, 1);
        chk("jalr_correct_addr", bus.out_correct_addr, 32'h200);
        chk("jalr_flush_count", bus.out_count, 0);
        chk("jalr_flush_alloc_tag", bus.out_alloc_tag, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
